// File: rtl/fifo_frame_unpacker_if.sv
// ----------------------------------------------------------------------------
// fifo_frame_unpacker_if
//   Bundles the FIFO read side and the beat output side of the frame unpacker.
//   Parameters: DW = FIFO word width, BW = output beat width.
//   Signals:
//     drain_en        permits new frame reads
//     fifo_empty      FIFO read-side empty flag
//     fifo_r_enable   FIFO read request, one cycle per word
//     data_from_fifo  FIFO read data, valid the cycle after fifo_r_enable
//     out_valid/out_ready/out_data/out_chan/out_last  beat stream
//     err_len         one-cycle pulse when a frame is dropped for its length
//     frame_cnt       count of frames fully delivered
//   Modports: master = the unpacker, slave = the FIFO/consumer environment.
// ----------------------------------------------------------------------------
interface fifo_frame_unpacker_if #(
   parameter int unsigned DW = 140,
   parameter int unsigned BW = 16
);
   logic          drain_en;
   logic          fifo_empty;
   logic          fifo_r_enable;
   logic [DW-1:0] data_from_fifo;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic [3:0]    out_chan;
   logic          out_last;
   logic          err_len;
   logic [15:0]   frame_cnt;

   modport master (
      input  drain_en, fifo_empty, data_from_fifo, out_ready,
      output fifo_r_enable, out_valid, out_data, out_chan, out_last,
             err_len, frame_cnt
   );

   modport slave (
      output drain_en, fifo_empty, data_from_fifo, out_ready,
      input  fifo_r_enable, out_valid, out_data, out_chan, out_last,
             err_len, frame_cnt
   );
endinterface

// File: rtl/fifo_frame_unpacker.sv
// ----------------------------------------------------------------------------
// fifo_frame_unpacker
//   Reads one frame word at a time from a FIFO and emits its payload as a
//   stream of BW-bit beats with valid/ready handshaking.
//   Word format: [139:136] chan, [135:132] nbeats, [131:128] reserved,
//   [127:0] payload, beat k = payload[16k+15:16k]. Frames with nbeats of 0
//   or above 8 are dropped and flagged with a one-cycle err_len pulse.
//   Ports:
//     clk_out  FIFO read-side clock, all logic on its rising edge
//     rst      synchronous active-high reset
//     bus      fifo_frame_unpacker_if.master (FIFO side + beat output side)
// ----------------------------------------------------------------------------
module fifo_frame_unpacker #(
   parameter int unsigned DW = 140,
   parameter int unsigned BW = 16
) (
   input logic                   clk_out,
   input logic                   rst,
   fifo_frame_unpacker_if.master bus
);
   localparam int unsigned NB_MAX = 8;
   localparam int unsigned PW     = NB_MAX * BW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_frame;
   logic [3:0]    r_chan;
   logic [3:0]    r_nbeats;
   logic [2:0]    r_idx;
   logic          r_out_valid;
   logic          r_out_last;
   logic [BW-1:0] r_out_data;
   logic          r_err_len;
   logic [15:0]   r_frame_cnt;

   logic [3:0]    w_word_chan;
   logic [3:0]    w_word_nbeats;
   logic          w_word_legal;
   logic [2:0]    w_next_idx;
   logic          w_rd;

   assign w_word_chan   = bus.data_from_fifo[DW-1 -: 4];
   assign w_word_nbeats = bus.data_from_fifo[DW-5 -: 4];
   assign w_word_legal  = (w_word_nbeats != 4'd0) && (w_word_nbeats <= 4'd8);
   assign w_next_idx    = r_idx + 3'd1;

   // Read request is combinational in IDLE; gating with rst keeps it low
   // even before the first reset edge has put the FSM into IDLE.
   assign w_rd = (r_state == S_IDLE) && bus.drain_en && !bus.fifo_empty && !rst;

   always_ff @(posedge clk_out) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_frame     <= '0;
         r_chan      <= '0;
         r_nbeats    <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_err_len   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_err_len <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_rd) r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_frame  <= bus.data_from_fifo[PW-1:0];
               r_chan   <= w_word_chan;
               r_nbeats <= w_word_nbeats;
               r_idx    <= '0;
               if (w_word_legal) begin
                  // Beat 0 is presented straight from the FIFO word so it
                  // appears in the first SEND cycle.
                  r_state     <= S_SEND;
                  r_out_valid <= 1'b1;
                  r_out_data  <= bus.data_from_fifo[BW-1:0];
                  r_out_last  <= (w_word_nbeats == 4'd1);
               end else begin
                  r_state   <= S_IDLE;
                  r_err_len <= 1'b1;
               end
            end
            S_SEND: begin
               if (bus.out_ready) begin
                  if (r_out_last) begin
                     r_state     <= S_IDLE;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_out_data  <= '0;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end else begin
                     r_idx      <= w_next_idx;
                     r_out_data <= r_frame[BW*w_next_idx +: BW];
                     r_out_last <= ({1'b0, w_next_idx} == (r_nbeats - 4'd1));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.fifo_r_enable = w_rd;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_data      = r_out_data;
   assign bus.out_chan      = r_chan;
   assign bus.out_last      = r_out_last;
   assign bus.err_len       = r_err_len;
   assign bus.frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// ----------------------------------------------------------------------------
// tb_fifo_frame_unpacker
//   Self-checking bench for fifo_frame_unpacker. A FIFO model feeds words,
//   a transaction-level reference (queue of expected beats per frame) predicts
//   every output each cycle, a vector table checks hand-derived frame results,
//   and short sequences cover gating, mid-frame reset and counter wrap.
// ----------------------------------------------------------------------------
module tb_fifo_frame_unpacker;
   localparam int unsigned DW = 140;
   localparam int unsigned BW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_frame_unpacker_if #(.DW(DW), .BW(BW)) bus ();

   fifo_frame_unpacker #(.DW(DW), .BW(BW)) dut (
      .clk_out (clk),
      .rst     (rst),
      .bus     (bus.master)
   );

   typedef struct {
      logic [3:0]  chan;
      logic [15:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic [3:0]   chan;
      logic [3:0]   nbeats;
      logic [127:0] payload;
      int unsigned  ready_mode;   // 0 always ready, 1 toggling, 2 random
      int unsigned  exp_beats;
      logic [15:0]  exp_first;
      logic [15:0]  exp_final;
      int unsigned  exp_err;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // stimulus knobs
   logic t_rst, t_drain, t_ready, t_empty_force;
   logic [139:0] fifo_q[$];

   // reference model state
   beat_t        send_q[$];
   logic         m_wait;
   logic [139:0] m_word;
   logic         m_err;
   logic [15:0]  m_fcnt;

   // observations
   beat_t cap_q[$];
   int    n_last_seen = 0;
   int    n_err_seen  = 0;
   int    ren_cyc     = -1;
   int    val_cyc     = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [139:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom, 12'($urandom)};
   endfunction

   function automatic logic [139:0] mk_word(input logic [3:0] ch, input logic [3:0] nb,
                                            input logic [127:0] pay);
      return {ch, nb, 4'($urandom), pay};
   endfunction

   // One clock cycle: drive inputs at negedge, check, then advance the model
   // to what the next cycle must show.
   task automatic tick();
      logic        exp_ren, exp_valid, empty, new_err;
      logic [3:0]  nb;
      int unsigned nbi;
      beat_t       b;
      @(negedge clk);
      empty               = t_empty_force || (fifo_q.size() == 0);
      rst                 = t_rst;
      bus.drain_en        = t_drain;
      bus.out_ready       = t_ready;
      bus.fifo_empty      = empty;
      bus.data_from_fifo  = m_wait ? m_word : rand_word();
      #1;
      exp_ren   = !t_rst && t_drain && !empty && !m_wait && (send_q.size() == 0);
      exp_valid = (send_q.size() != 0);
      chk("fifo_r_enable", 32'(bus.fifo_r_enable), 32'(exp_ren));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("out_data", 32'(bus.out_data), 32'(send_q[0].data));
         chk("out_chan", 32'(bus.out_chan), 32'(send_q[0].chan));
         chk("out_last", 32'(bus.out_last), 32'(send_q[0].last));
      end else begin
         chk("out_data_idle", 32'(bus.out_data), 32'd0);
         chk("out_last_idle", 32'(bus.out_last), 32'd0);
      end
      chk("err_len", 32'(bus.err_len), 32'(m_err));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));

      if (bus.fifo_r_enable === 1'b1 && ren_cyc < 0) ren_cyc = cyc;
      if (bus.out_valid === 1'b1 && val_cyc < 0) val_cyc = cyc;
      if (bus.out_valid === 1'b1 && t_ready) begin
         b.chan = bus.out_chan;
         b.data = bus.out_data;
         b.last = bus.out_last;
         cap_q.push_back(b);
         if (b.last) n_last_seen++;
      end
      if (bus.err_len === 1'b1) n_err_seen++;

      if (t_rst) begin
         send_q.delete();
         m_wait = 1'b0;
         m_err  = 1'b0;
         m_fcnt = '0;
      end else begin
         new_err = 1'b0;
         if (m_wait) begin
            nb  = m_word[135:132];
            nbi = nb;
            if (nbi >= 1 && nbi <= 8) begin
               for (int unsigned k = 0; k < nbi; k++) begin
                  b.chan = m_word[139:136];
                  b.data = m_word[16*k +: 16];
                  b.last = (k == nbi - 1);
                  send_q.push_back(b);
               end
            end else begin
               new_err = 1'b1;
            end
            m_wait = 1'b0;
         end else if (exp_valid && t_ready) begin
            b = send_q.pop_front();
            if (b.last) m_fcnt = m_fcnt + 16'd1;
         end
         m_err = new_err;
         if (exp_ren) begin
            m_word = fifo_q.pop_front();
            m_wait = 1'b1;
         end
      end
      cyc++;
   endtask

   // Run until the DUT ends `n` more frames (last beat or err_len), bounded.
   task automatic run_frames(input int n, input int budget, input int unsigned mode,
                             input string name);
      int target;
      int spent;
      target = n_last_seen + n_err_seen + n;
      spent  = 0;
      while ((n_last_seen + n_err_seen) < target && spent < budget) begin
         if (mode == 0) t_ready = 1'b1;
         else if (mode == 1) t_ready = (spent % 2 == 0);
         else t_ready = 1'($urandom_range(0, 1));
         tick();
         spent++;
      end
      chk(name, 32'((n_last_seen + n_err_seen) >= target), 32'd1);
      t_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[7];
      int          ren_hits;
      int          err_before;
      logic [15:0] exp_cnt;
      beat_t       fb, lb;

      vecs[0] = '{chan:4'h3, nbeats:4'd2,
                  payload:{96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'hBEEF_1234},
                  ready_mode:0, exp_beats:2, exp_first:16'h1234, exp_final:16'hBEEF, exp_err:0};
      vecs[1] = '{chan:4'hA, nbeats:4'd8,
                  payload:128'h8888_7777_6666_5555_4444_3333_2222_1111,
                  ready_mode:1, exp_beats:8, exp_first:16'h1111, exp_final:16'h8888, exp_err:0};
      vecs[2] = '{chan:4'h5, nbeats:4'd0, payload:128'h1,
                  ready_mode:0, exp_beats:0, exp_first:16'h0, exp_final:16'h0, exp_err:1};
      vecs[3] = '{chan:4'h6, nbeats:4'd9, payload:{8{16'hFFFF}},
                  ready_mode:0, exp_beats:0, exp_first:16'h0, exp_final:16'h0, exp_err:1};
      vecs[4] = '{chan:4'hF, nbeats:4'd1, payload:{{7{16'h5555}}, 16'hC0DE},
                  ready_mode:1, exp_beats:1, exp_first:16'hC0DE, exp_final:16'hC0DE, exp_err:0};
      vecs[5] = '{chan:4'h0, nbeats:4'hF, payload:{8{16'h1234}},
                  ready_mode:0, exp_beats:0, exp_first:16'h0, exp_final:16'h0, exp_err:1};
      vecs[6] = '{chan:4'h9, nbeats:4'd4, payload:{64'h0, 64'hDDDD_CCCC_BBBB_AAAA},
                  ready_mode:2, exp_beats:4, exp_first:16'hAAAA, exp_final:16'hDDDD, exp_err:0};

      rst                = 1'b1;
      bus.drain_en       = 1'b0;
      bus.fifo_empty     = 1'b1;
      bus.out_ready      = 1'b0;
      bus.data_from_fifo = '0;
      t_rst = 1'b1; t_drain = 1'b1; t_ready = 1'b1; t_empty_force = 1'b0;
      m_wait = 1'b0; m_word = '0; m_err = 1'b0; m_fcnt = '0;

      // Reset: FIFO not empty and drain enabled, yet no read while rst=1.
      fifo_q.push_back(mk_word(4'h2, 4'd1, {8{16'h0042}}));
      tick();
      tick();
      chk("rst_ren", 32'(bus.fifo_r_enable), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_chan", 32'(bus.out_chan), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
      chk("rst_err", 32'(bus.err_len), 32'd0);
      chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
      t_rst = 1'b0;
      run_frames(1, 20, 0, "first_frame_done");
      tick();
      chk("first_frame_cnt", 32'(bus.frame_cnt), 32'd1);
      t_rst = 1'b1;
      tick();
      t_rst = 1'b0;
      tick();

      // Table of single frames with hand-derived results.
      exp_cnt = '0;
      for (int i = 0; i < 7; i++) begin
         cap_q.delete();
         ren_cyc    = -1;
         val_cyc    = -1;
         err_before = n_err_seen;
         fifo_q.push_back(mk_word(vecs[i].chan, vecs[i].nbeats, vecs[i].payload));
         t_drain = 1'b1;
         run_frames(1, 40, vecs[i].ready_mode, "vec_done");
         tick();
         tick();
         if (vecs[i].exp_beats > 0) exp_cnt = exp_cnt + 16'd1;
         chk("vec_beats", 32'(cap_q.size()), 32'(vecs[i].exp_beats));
         chk("vec_err", 32'(n_err_seen - err_before), 32'(vecs[i].exp_err));
         chk("vec_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
         if (vecs[i].exp_beats > 0) begin
            fb = (cap_q.size() > 0) ? cap_q[0] : '{chan:4'h0, data:16'h0, last:1'b0};
            lb = (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : '{chan:4'h0, data:16'h0, last:1'b0};
            chk("vec_first", 32'(fb.data), 32'(vecs[i].exp_first));
            chk("vec_final", 32'(lb.data), 32'(vecs[i].exp_final));
            chk("vec_chan", 32'(fb.chan), 32'(vecs[i].chan));
            chk("vec_final_last", 32'(lb.last), 32'd1);
            chk("vec_latency", 32'(val_cyc - ren_cyc), 32'd2);
         end else begin
            chk("vec_no_valid", 32'(val_cyc), 32'hFFFF_FFFF);
         end
      end

      // Two 8-beat frames back to back under toggling backpressure.
      fifo_q.push_back(mk_word(4'h7, 4'd8, {$urandom, $urandom, $urandom, $urandom}));
      fifo_q.push_back(mk_word(4'h8, 4'd8, {$urandom, $urandom, $urandom, $urandom}));
      run_frames(2, 80, 1, "b2b_done");

      // Gating: drain off, then FIFO empty, 20 cycles each.
      fifo_q.push_back(mk_word(4'hC, 4'd3, {8{16'h3C3C}}));
      t_drain = 1'b0;
      ren_hits = 0;
      repeat (20) begin
         tick();
         if (bus.fifo_r_enable === 1'b1) ren_hits++;
      end
      chk("gate_drain_off", 32'(ren_hits), 32'd0);
      t_drain = 1'b1;
      t_empty_force = 1'b1;
      ren_hits = 0;
      repeat (20) begin
         tick();
         if (bus.fifo_r_enable === 1'b1) ren_hits++;
      end
      chk("gate_empty", 32'(ren_hits), 32'd0);
      t_empty_force = 1'b0;
      val_cyc = -1;
      for (int k = 0; k < 10 && val_cyc < 0; k++) tick();
      chk("gate_send_reached", 32'(val_cyc >= 0), 32'd1);
      t_drain = 1'b0;
      run_frames(1, 20, 0, "gate_drain_drop_done");
      t_drain = 1'b1;

      // Reset during the 3rd beat of an 8-beat frame.
      cap_q.delete();
      fifo_q.push_back(mk_word(4'hD, 4'd8, {8{16'h9999}}));
      for (int k = 0; k < 20 && cap_q.size() < 2; k++) tick();
      chk("midrst_two_beats", 32'(cap_q.size()), 32'd2);
      t_rst = 1'b1;
      tick();
      t_rst = 1'b0;
      t_drain = 1'b0;
      tick();
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_data", 32'(bus.out_data), 32'd0);
      chk("midrst_last", 32'(bus.out_last), 32'd0);
      chk("midrst_chan", 32'(bus.out_chan), 32'd0);
      chk("midrst_cnt", 32'(bus.frame_cnt), 32'd0);
      cap_q.delete();
      fifo_q.push_back(mk_word(4'h4, 4'd2, {{6{16'h0000}}, 16'hF0F0, 16'h0F0F}));
      t_drain = 1'b1;
      run_frames(1, 20, 0, "midrst_next_done");
      tick();
      fb = (cap_q.size() > 0) ? cap_q[0] : '{chan:4'h0, data:16'h0, last:1'b0};
      chk("midrst_next_first", 32'(fb.data), 32'h0F0F);
      chk("midrst_next_chan", 32'(fb.chan), 32'h4);
      chk("midrst_next_cnt", 32'(bus.frame_cnt), 32'd1);

      // Counter wrap, starting from a preloaded count of 65534.
      force dut.r_frame_cnt = 16'hFFFE;
      #1;
      release dut.r_frame_cnt;
      m_fcnt = 16'hFFFE;
      fifo_q.push_back(mk_word(4'h1, 4'd1, {8{16'h0001}}));
      run_frames(1, 20, 0, "wrap_a_done");
      tick();
      chk("wrap_ffff", 32'(bus.frame_cnt), 32'h0000_FFFF);
      fifo_q.push_back(mk_word(4'h1, 4'd1, {8{16'h0002}}));
      run_frames(1, 20, 0, "wrap_b_done");
      tick();
      chk("wrap_zero", 32'(bus.frame_cnt), 32'd0);

      // Randomised traffic against the reference model.
      for (int k = 0; k < 3000; k++) begin
         if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) == 0)
               fifo_q.push_back(mk_word(4'($urandom), 4'($urandom_range(0, 15)),
                                        {$urandom, $urandom, $urandom, $urandom}));
            else
               fifo_q.push_back(mk_word(4'($urandom), 4'($urandom_range(1, 8)),
                                        {$urandom, $urandom, $urandom, $urandom}));
         end
         t_drain       = ($urandom_range(0, 9) != 0);
         t_ready       = ($urandom_range(0, 3) != 0);
         t_empty_force = ($urandom_range(0, 9) == 0);
         t_rst         = ($urandom_range(0, 199) == 0);
         tick();
      end
      t_rst = 1'b0; t_drain = 1'b1; t_ready = 1'b1; t_empty_force = 1'b0;
      repeat (60) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
